// File: rtl/countdown_ctrl_if.sv
// Button inputs and display-side outputs of the countdown control stage.
// The master side drives the raw buttons; the slave side is the controller.
interface countdown_ctrl_if;
  logic       btn_start_pause;
  logic       btn_clear;
  logic [3:0] digit;
  logic       running;
  logic       tick;
  logic       expired;

  modport master (
    output btn_start_pause, btn_clear,
    input  digit, running, tick, expired
  );

  modport slave (
    input  btn_start_pause, btn_clear,
    output digit, running, tick, expired
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown control: debounced start/pause and clear buttons, prescaled step tick,
// and a run state machine producing the hex digit for the display decoder.
module countdown_ctrl #(
  parameter int unsigned TICK_CYCLES     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [3:0]  START_VALUE     = 4'hF,
  parameter bit          AUTO_RELOAD     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned NB = 2;  // index 0 = start/pause, 1 = clear

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1, sync2, level, level_d;
  logic [DW-1:0] db_cnt [NB];
  logic          press_start, press_clear;

  state_t        state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          expired_q, expired_d;
  logic          running_q, running_d;

  assign raw = {bus.btn_clear, bus.btn_start_pause};

  // Two-flop synchronizer plus stable-count debounce for each button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < int'(NB); i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press events fire only on debounced rising edges.
  assign press_start = level[0] & ~level_d[0];
  assign press_clear = level[1] & ~level_d[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digit_q   <= START_VALUE;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

  // A start press in RUN still lets a coincident tick take effect before pausing.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    if (press_clear) begin
      state_d = ST_IDLE;
      digit_d = START_VALUE;
      pre_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pre_d = '0;
          if (press_start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pre_q == PW'(TICK_CYCLES - 1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (digit_q != 4'd0) begin
              digit_d = digit_q - 4'd1;
            end else begin
              expired_d = 1'b1;
              if (AUTO_RELOAD) digit_d = START_VALUE;
              else             state_d = ST_DONE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
          if (press_start) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (press_start) state_d = ST_RUN;
        end
        ST_DONE: begin
          pre_d = '0;
          if (press_start) begin
            digit_d = START_VALUE;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  assign bus.digit   = digit_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: two instances (auto-reload on/off) share button stimulus;
// a reference model queues expected outputs each cycle and a monitor compares them.
module tb_countdown_ctrl;

  localparam int unsigned TICK = 10;
  localparam int unsigned DEB  = 4;
  localparam logic [3:0]  SV   = 4'd3;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  typedef struct packed {
    logic [3:0] digit;
    logic       running;
    logic       tick;
    logic       expired;
  } obs_t;

  bit   clk = 1'b0;
  logic rst_n;
  logic btn_s, btn_c;

  int checks = 0;
  int errors = 0;

  countdown_ctrl_if if_ar ();
  countdown_ctrl_if if_st ();

  assign if_ar.btn_start_pause = btn_s;
  assign if_ar.btn_clear       = btn_c;
  assign if_st.btn_start_pause = btn_s;
  assign if_st.btn_clear       = btn_c;

  countdown_ctrl #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .START_VALUE(SV), .AUTO_RELOAD(1'b1))
    dut_ar (.clk(clk), .rst_n(rst_n), .bus(if_ar.slave));
  countdown_ctrl #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .START_VALUE(SV), .AUTO_RELOAD(1'b0))
    dut_st (.clk(clk), .rst_n(rst_n), .bus(if_st.slave));

  always #5 clk = ~clk;

  // Reference model state: [0] = auto-reload instance, [1] = stop-in-done instance.
  mstate_t m_st [2];
  int      m_digit [2];
  int      m_pre [2];
  bit      s1 [2], s2 [2], lev [2], lev_prev [2];
  bit      hist [2][DEB];
  int      hv [2];
  obs_t    exp_q0 [$];
  obs_t    exp_q1 [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_digit[i] = int'(SV); m_pre[i] = 0;
      s1[i] = 0; s2[i] = 0; lev[i] = 0; lev_prev[i] = 0; hv[i] = 0;
    end
  endtask

  task automatic model_step();
    bit raw [2];
    bit press [2];
    bit all_diff;
    bit tk, ex;
    obs_t o;
    raw[0] = btn_s; raw[1] = btn_c;
    // A button level is accepted once the last DEB synchronized samples all disagree with it.
    for (int b = 0; b < 2; b++) begin
      press[b]    = lev[b] && !lev_prev[b];
      lev_prev[b] = lev[b];
      for (int k = int'(DEB) - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = s2[b];
      if (hv[b] < int'(DEB)) hv[b]++;
      if (hv[b] == int'(DEB)) begin
        all_diff = 1'b1;
        for (int k = 0; k < int'(DEB); k++) if (hist[b][k] == lev[b]) all_diff = 1'b0;
        if (all_diff) lev[b] = !lev[b];
      end
      s2[b] = s1[b];
      s1[b] = raw[b];
    end
    for (int i = 0; i < 2; i++) begin
      tk = 1'b0; ex = 1'b0;
      if (press[1]) begin
        m_st[i] = M_IDLE; m_digit[i] = int'(SV); m_pre[i] = 0;
      end else begin
        case (m_st[i])
          M_IDLE:  if (press[0]) begin m_st[i] = M_RUN; m_pre[i] = 0; end
          M_RUN: begin
            m_pre[i]++;
            if (m_pre[i] == int'(TICK)) begin
              m_pre[i] = 0;
              tk = 1'b1;
              if (m_digit[i] > 0) m_digit[i]--;
              else begin
                ex = 1'b1;
                if (i == 0) m_digit[i] = int'(SV);
                else        m_st[i] = M_DONE;
              end
            end
            if (press[0]) m_st[i] = M_PAUSE;
          end
          M_PAUSE: if (press[0]) m_st[i] = M_RUN;
          M_DONE:  if (press[0]) begin m_st[i] = M_RUN; m_digit[i] = int'(SV); m_pre[i] = 0; end
          default: m_st[i] = M_IDLE;
        endcase
      end
      o.digit   = 4'(m_digit[i]);
      o.running = (m_st[i] == M_RUN);
      o.tick    = tk;
      o.expired = ex;
      if (i == 0) exp_q0.push_back(o);
      else        exp_q1.push_back(o);
    end
  endtask

  task automatic model_push_reset();
    obs_t o;
    o.digit = SV; o.running = 1'b0; o.tick = 1'b0; o.expired = 1'b0;
    exp_q0.push_back(o);
    exp_q1.push_back(o);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      model_push_reset();
    end else begin
      model_step();
    end
  end

  task automatic cmp_obs(input string nm, input obs_t got, input obs_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s t=%0t got digit=%0d running=%0b tick=%0b expired=%0b required digit=%0d running=%0b tick=%0b expired=%0b",
               nm, $time, got.digit, got.running, got.tick, got.expired,
               req.digit, req.running, req.tick, req.expired);
    end
  endtask

  // Monitor: one expected record per cycle per instance, compared away from the active edge.
  always @(negedge clk) begin
    obs_t g, e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      g = {if_ar.digit, if_ar.running, if_ar.tick, if_ar.expired};
      cmp_obs("reload_dut", g, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      g = {if_st.digit, if_st.running, if_st.tick, if_st.expired};
      cmp_obs("stop_dut", g, e);
    end
  end

  task automatic check(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d required=%0d", nm, $time, got, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start(input int hold);
    btn_s = 1'b1; cyc(hold);
    btn_s = 1'b0; cyc(int'(DEB) + 4);
  endtask

  // Wait (bounded) until the model's reload instance is running at the given digit/prescale.
  task automatic wait_model(input int d, input int p, input string nm);
    int k;
    k = 0;
    while (!(m_st[0] == M_RUN && (d < 0 || m_digit[0] == d) && (p < 0 || m_pre[0] == p)) && k < 300) begin
      cyc(1);
      k++;
    end
    check(nm, int'(k < 300), 1);
  endtask

  initial begin
    rst_n = 1'b0; btn_s = 1'b0; btn_c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Hold start for 20 cycles, then let both instances run through expiry.
    btn_s = 1'b1; cyc(20);
    btn_s = 1'b0; cyc(50);
    check("stop_done_digit", int'(if_st.digit), 0);
    check("stop_done_running", int'(if_st.running), 0);

    // Clear, then a bouncing start button that never settles long enough.
    btn_c = 1'b1; cyc(8); btn_c = 1'b0; cyc(8);
    for (int i = 0; i < 15; i++) begin
      btn_s = ~btn_s; cyc(2);
    end
    btn_s = 1'b0; cyc(20);
    check("bounce_running", int'(if_ar.running), 0);
    check("bounce_digit", int'(if_ar.digit), int'(SV));

    // Pause at prescale 6, stay frozen, then resume.
    press_start(8);
    wait_model(-1, 0, "wait_pre0");
    btn_s = 1'b1; cyc(8); btn_s = 1'b0; cyc(42);
    check("paused_running", int'(if_ar.running), 0);
    press_start(8);
    cyc(20);

    // Clear during RUN at digit 1, then clear and start together.
    wait_model(1, 2, "wait_digit1");
    btn_c = 1'b1; cyc(8); btn_c = 1'b0; cyc(8);
    check("clear_running", int'(if_ar.running), 0);
    check("clear_digit", int'(if_ar.digit), int'(SV));
    btn_s = 1'b1; btn_c = 1'b1; cyc(8);
    btn_s = 1'b0; btn_c = 1'b0; cyc(10);
    check("both_running", int'(if_ar.running), 0);

    // Start press landing on the tick at digit 2.
    press_start(8);
    wait_model(2, 3, "wait_tick_align");
    btn_s = 1'b1; cyc(7);
    check("tick_pause_digit", int'(if_ar.digit), 1);
    check("tick_pause_running", int'(if_ar.running), 0);
    btn_s = 1'b0; cyc(10);

    // Asynchronous reset mid-count, released with start held.
    press_start(8);
    cyc(15);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_digit_ar", int'(if_ar.digit), int'(SV));
    check("async_rst_running_ar", int'(if_ar.running), 0);
    check("async_rst_digit_st", int'(if_st.digit), int'(SV));
    check("async_rst_running_st", int'(if_st.running), 0);
    btn_s = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(12);
    btn_s = 1'b0; cyc(10);

    // Randomized button activity.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       begin btn_c = 1'b1; cyc($urandom_range(1, 8)); btn_c = 1'b0; end
        1, 2, 3: begin btn_s = 1'b1; cyc($urandom_range(1, 9)); btn_s = 1'b0; end
        4:       begin btn_s = 1'b1; btn_c = 1'b1; cyc($urandom_range(2, 7));
                       btn_s = 1'b0; btn_c = 1'b0; end
        default: cyc($urandom_range(1, 30));
      endcase
      cyc($urandom_range(1, 10));
    end

    btn_s = 1'b0; btn_c = 1'b0;
    cyc(5);
    @(negedge clk); #1;
    check("queue_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
